// File: rtl/perceptron_trainer_pkg.sv
// Shared types and width helpers for perceptron_trainer.
// PERCEPTRON_TRAINER_EVAL_EN adds the EVAL/EDRAIN states to the state enum.
package perceptron_trainer_pkg;

  localparam int unsigned X_W     = 18;
  localparam int unsigned Y_W     = 48;
  localparam int unsigned LR_W    = 18;
  localparam int unsigned EPOCH_W = 16;

  typedef logic [Y_W-1:0]     y_t;
  typedef logic [LR_W-1:0]    lr_t;
  typedef logic [EPOCH_W-1:0] epoch_t;

`ifdef PERCEPTRON_TRAINER_EVAL_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_CHECK,
    ST_EVAL,
    ST_EDRAIN
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_CHECK
  } state_e;
`endif

  // Sample record is parameterised on the input count, so it is built from this.
  function automatic int unsigned sample_w(int unsigned n);
    return X_W * n + Y_W;
  endfunction

  function automatic int unsigned addr_w(int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned err_w(int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/perceptron_trainer_tag_pipe.sv
// Delay line carrying {valid, expected_y} alongside the perceptron pipeline.
// empty_o means nothing remains behind the output stage.
module trainer_tag_pipe #(
  parameter int unsigned LATENCY = 3,
  parameter int unsigned W       = 48
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o,
  output logic         empty_o
);

  logic [LATENCY-1:0] valid_q;
  logic [W-1:0]       data_q [LATENCY];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= in_valid_i;
      data_q[0]  <= in_data_i;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign out_valid_o = valid_q[LATENCY-1];
  assign out_data_o  = data_q[LATENCY-1];

  // The output stage is graded this cycle, so it does not count as pending.
  always_comb begin
    empty_o = 1'b1;
    for (int unsigned i = 0; i + 1 < LATENCY; i++) begin
      if (valid_q[i]) empty_o = 1'b0;
    end
  end

endmodule

// File: rtl/perceptron_trainer.sv
// Perceptron training sequencer: replays a sample memory, grades y, repeats epochs.
// PERCEPTRON_TRAINER_EVAL_EN adds a final untrained evaluation pass (eval_errors).
module perceptron_trainer
  import perceptron_trainer_pkg::*;
#(
  parameter int unsigned N            = 8,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned PIPE_LATENCY = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ld_we,
  input  logic [addr_w(DEPTH)-1:0]  ld_addr,
  input  logic [X_W*N-1:0]          ld_x,
  input  logic [Y_W-1:0]            ld_exp_y,
  input  logic [err_w(DEPTH)-1:0]   num_samples,
  input  logic [EPOCH_W-1:0]        max_epochs,
  input  logic [LR_W-1:0]           learning_rate,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      converged,
  output logic [EPOCH_W-1:0]        epoch_count,
  output logic [err_w(DEPTH)-1:0]   error_count,
  output logic [err_w(DEPTH)-1:0]   eval_errors,
  output logic [X_W*N-1:0]          p_x,
  output logic                      p_train,
  output logic [LR_W-1:0]           p_learning_rate,
  output logic [Y_W-1:0]            p_expected_y,
  input  logic [Y_W-1:0]            p_y
);

  localparam int unsigned ADDR_W = addr_w(DEPTH);
  localparam int unsigned ERR_W  = err_w(DEPTH);
  localparam int unsigned XV_W   = X_W * N;

  typedef struct packed {
    logic [XV_W-1:0] x;
    y_t              exp_y;
  } sample_t;

  sample_t mem_q [DEPTH];

  state_e            state_q, state_d;
  logic [ERR_W-1:0]  idx_q, idx_d;
  logic [ERR_W-1:0]  n_q, n_d;
  epoch_t            max_q, max_d;
  lr_t               lr_q, lr_d;
  epoch_t            epoch_q, epoch_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [ERR_W-1:0]  acc_q, acc_d;
  logic              conv_q, conv_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic [XV_W-1:0]   px_q, px_d;
  logic              ptrain_q, ptrain_d;
  y_t                pexp_q, pexp_d;
  logic              issue_q, issue_d;
`ifdef PERCEPTRON_TRAINER_EVAL_EN
  logic [ERR_W-1:0]  eval_q, eval_d;
`endif

  logic    tag_valid;
  y_t      tag_exp;
  logic    tags_empty;
  logic    grade_err;
  epoch_t  ep_next;
  sample_t rd;
  logic    finish;

  // Host writes are locked out while busy so replay never races a load.
  always_ff @(posedge clk) begin
    if (ld_we && !busy_q) begin
      mem_q[ld_addr] <= '{x: ld_x, exp_y: ld_exp_y};
    end
  end

  // Tags enter from the registered p_* outputs, so they line up with p_y.
  trainer_tag_pipe #(
    .LATENCY (PIPE_LATENCY),
    .W       (Y_W)
  ) u_tags (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (issue_q),
    .in_data_i   (pexp_q),
    .out_valid_o (tag_valid),
    .out_data_o  (tag_exp),
    .empty_o     (tags_empty)
  );

  assign grade_err = tag_valid && (p_y != tag_exp);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    n_d      = n_q;
    max_d    = max_q;
    lr_d     = lr_q;
    epoch_d  = epoch_q;
    err_d    = err_q;
    conv_d   = conv_q;
    done_d   = 1'b0;
    acc_d    = grade_err ? acc_q + ERR_W'(1) : acc_q;
    px_d     = '0;
    ptrain_d = 1'b0;
    pexp_d   = '0;
    issue_d  = 1'b0;
    ep_next  = (epoch_q == '1) ? epoch_q : epoch_q + EPOCH_W'(1);
    rd       = mem_q[idx_q[ADDR_W-1:0]];
    finish   = 1'b0;
`ifdef PERCEPTRON_TRAINER_EVAL_EN
    eval_d   = eval_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          n_d     = num_samples;
          max_d   = max_epochs;
          lr_d    = learning_rate;
          epoch_d = '0;
          conv_d  = 1'b0;
          acc_d   = '0;
`ifdef PERCEPTRON_TRAINER_EVAL_EN
          eval_d  = '0;
`endif
          if (num_samples == '0 || max_epochs == '0) begin
            done_d = 1'b1;
            conv_d = (num_samples == '0);
          end else begin
            state_d  = ST_RUN;
            px_d     = mem_q[0].x;
            pexp_d   = mem_q[0].exp_y;
            ptrain_d = 1'b1;
            issue_d  = 1'b1;
            idx_d    = ERR_W'(1);
          end
        end
      end

      ST_RUN: begin
        if (idx_q < n_q) begin
          px_d     = rd.x;
          pexp_d   = rd.exp_y;
          ptrain_d = 1'b1;
          issue_d  = 1'b1;
          idx_d    = idx_q + ERR_W'(1);
        end else begin
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (tags_empty) state_d = ST_CHECK;
      end

      ST_CHECK: begin
        err_d   = acc_q;
        epoch_d = ep_next;
        acc_d   = '0;
        if (acc_q == '0) conv_d = 1'b1;
        finish  = (acc_q == '0) || (ep_next == max_q);
        px_d    = mem_q[0].x;
        pexp_d  = mem_q[0].exp_y;
        idx_d   = ERR_W'(1);
        if (!finish) begin
          state_d  = ST_RUN;
          ptrain_d = 1'b1;
          issue_d  = 1'b1;
        end else begin
`ifdef PERCEPTRON_TRAINER_EVAL_EN
          state_d = ST_EVAL;
          issue_d = 1'b1;
`else
          state_d = ST_IDLE;
          done_d  = 1'b1;
          px_d    = '0;
          pexp_d  = '0;
`endif
        end
      end

`ifdef PERCEPTRON_TRAINER_EVAL_EN
      ST_EVAL: begin
        if (idx_q < n_q) begin
          px_d    = rd.x;
          pexp_d  = rd.exp_y;
          issue_d = 1'b1;
          idx_d   = idx_q + ERR_W'(1);
        end else begin
          state_d = ST_EDRAIN;
        end
      end

      // acc_d already includes the last tag graded this cycle.
      ST_EDRAIN: begin
        if (tags_empty) begin
          eval_d  = acc_d;
          acc_d   = '0;
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      n_q      <= '0;
      max_q    <= '0;
      lr_q     <= '0;
      epoch_q  <= '0;
      err_q    <= '0;
      acc_q    <= '0;
      conv_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      px_q     <= '0;
      ptrain_q <= 1'b0;
      pexp_q   <= '0;
      issue_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      n_q      <= n_d;
      max_q    <= max_d;
      lr_q     <= lr_d;
      epoch_q  <= epoch_d;
      err_q    <= err_d;
      acc_q    <= acc_d;
      conv_q   <= conv_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      px_q     <= px_d;
      ptrain_q <= ptrain_d;
      pexp_q   <= pexp_d;
      issue_q  <= issue_d;
    end
  end

`ifdef PERCEPTRON_TRAINER_EVAL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) eval_q <= '0;
    else     eval_q <= eval_d;
  end
  assign eval_errors = eval_q;
`else
  assign eval_errors = '0;
`endif

  assign busy            = busy_q;
  assign done            = done_q;
  assign converged       = conv_q;
  assign epoch_count     = epoch_q;
  assign error_count     = err_q;
  assign p_x             = px_q;
  assign p_train         = ptrain_q;
  assign p_learning_rate = lr_q;
  assign p_expected_y    = pexp_q;

endmodule

// File: tb/tb_perceptron_trainer.sv
// Scoreboard bench for perceptron_trainer with a 3-cycle behavioural perceptron.
module tb_perceptron_trainer;

  localparam int unsigned N = 8;

`ifdef PERCEPTRON_TRAINER_EVAL_EN
  localparam int EVX = 7;
`else
  localparam int EVX = 0;
`endif

  logic             clk;
  logic             rst;
  logic             ld_we;
  logic [3:0]       ld_addr;
  logic [18*N-1:0]  ld_x;
  logic [47:0]      ld_exp_y;
  logic [4:0]       num_samples;
  logic [15:0]      max_epochs;
  logic [17:0]      learning_rate;
  logic             start;
  logic             busy;
  logic             done;
  logic             converged;
  logic [15:0]      epoch_count;
  logic [4:0]       error_count;
  logic [4:0]       eval_errors;
  logic [18*N-1:0]  p_x;
  logic             p_train;
  logic [17:0]      p_learning_rate;
  logic [47:0]      p_expected_y;
  logic [47:0]      p_y;

  perceptron_trainer #(.N(N), .DEPTH(16), .PIPE_LATENCY(3)) dut (
    .clk             (clk),
    .rst             (rst),
    .ld_we           (ld_we),
    .ld_addr         (ld_addr),
    .ld_x            (ld_x),
    .ld_exp_y        (ld_exp_y),
    .num_samples     (num_samples),
    .max_epochs      (max_epochs),
    .learning_rate   (learning_rate),
    .start           (start),
    .busy            (busy),
    .done            (done),
    .converged       (converged),
    .epoch_count     (epoch_count),
    .error_count     (error_count),
    .eval_errors     (eval_errors),
    .p_x             (p_x),
    .p_train         (p_train),
    .p_learning_rate (p_learning_rate),
    .p_expected_y    (p_expected_y),
    .p_y             (p_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          tstart;
    int          lat;
    bit          conv;
    int          ep;
    int          er;
    int          ev;
    int          moff;
    int          merr;
    logic [17:0] lr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   mode   = 0;

  // Perceptron stand-in: y = expected_y three cycles later, corrupted per mode.
  // mode 0 exact, 1 always zero, 2 wrong on samples 1/2 of first epoch, 3 wrong on sample 0 untrained.
  logic [47:0] m_s0, m_s1, m_s2;
  int          ep_cnt = 0;
  assign p_y = m_s2;

  always @(posedge clk) begin
    logic [17:0] sidx;
    logic [47:0] yv;
    sidx = p_x[17:0];
    if (!busy) ep_cnt = 0;
    if (p_train && sidx == 18'd0) ep_cnt = ep_cnt + 1;
    yv = p_expected_y;
    case (mode)
      1: yv = '0;
      2: if (p_train && ep_cnt == 1) begin
           if (sidx == 18'd1)      yv = yv ^ 48'h0000_0000_0001;
           else if (sidx == 18'd2) yv = yv ^ 48'h8000_0000_0000;
         end
      3: if (!p_train && sidx == 18'd0) yv = yv ^ 48'h0000_0001_0000;
      default: ;
    endcase
    m_s0 <= yv;
    m_s1 <= m_s0;
    m_s2 <= m_s1;
  end

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: reset/idle invariants every cycle, scoreboard pop on each done pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_p_train", 64'(p_train), 0);
        chk("rst_converged", 64'(converged), 0);
        chk("rst_epoch_count", 64'(epoch_count), 0);
        chk("rst_error_count", 64'(error_count), 0);
        chk("rst_eval_errors", 64'(eval_errors), 0);
        chk("rst_p_lr", 64'(p_learning_rate), 0);
        chk("rst_p_exp_y", 64'(p_expected_y), 0);
        chk("rst_p_x_zero", 64'(p_x == '0), 1);
      end else begin
        if (!busy) begin
          chk("idle_p_train", 64'(p_train), 0);
          chk("idle_p_x_zero", 64'(p_x == '0), 1);
        end
        if (exp_q.size() != 0) begin
          e = exp_q[0];
          if (e.moff != 0 && cyc == e.tstart + e.moff)
            chk("mid_error_count", 64'(error_count), 64'(e.merr));
          if (!done && (cyc - e.tstart) > e.lat + 20) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done at +%0d", e.lat);
            void'(exp_q.pop_front());
          end
        end
        if (done) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
          end else begin
            e = exp_q.pop_front();
            chk("done_latency", 64'(cyc - e.tstart), 64'(e.lat));
            chk("done_busy", 64'(busy), 0);
            chk("converged", 64'(converged), 64'(e.conv));
            chk("epoch_count", 64'(epoch_count), 64'(e.ep));
            chk("error_count", 64'(error_count), 64'(e.er));
            chk("eval_errors", 64'(eval_errors), 64'(e.ev));
            chk("p_learning_rate", 64'(p_learning_rate), 64'(e.lr));
          end
        end
      end
    end
  end

  logic [47:0] y_tab [4];

  task automatic load(input int i);
    logic [18*N-1:0] x;
    x = '0;
    for (int j = 0; j < int'(N); j++) x[j*18 +: 18] = 18'(i + 16 * j);
    @(negedge clk);
    ld_we    = 1'b1;
    ld_addr  = 4'(i);
    ld_x     = x;
    ld_exp_y = y_tab[i];
    @(negedge clk);
    ld_we    = 1'b0;
  endtask

  task automatic run(input int n, input int me, input int md, input logic [17:0] lr,
                     input int lat, input bit conv, input int ep, input int er, input int ev,
                     input int moff, input int merr, input bit poke);
    exp_t e;
    @(negedge clk);
    mode          = md;
    num_samples   = 5'(n);
    max_epochs    = 16'(me);
    learning_rate = lr;
    start         = 1'b1;
    e.tstart = cyc; e.lat = lat; e.conv = conv; e.ep = ep; e.er = er;
    e.ev = ev; e.moff = moff; e.merr = merr; e.lr = lr;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    if (poke) begin
      ld_we    = 1'b1;
      ld_addr  = 4'd0;
      ld_exp_y = '0;
      @(negedge clk);
      ld_we    = 1'b0;
    end
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    y_tab[0] = 48'h0000_0000_1234;
    y_tab[1] = 48'hFFFF_FFFF_FFFF;
    y_tab[2] = 48'h8000_0000_0000;
    y_tab[3] = 48'h0000_0ABC_DEF0;
    rst = 1'b1; ld_we = 1'b0; ld_addr = '0; ld_x = '0; ld_exp_y = '0;
    num_samples = '0; max_epochs = '0; learning_rate = '0; start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) load(i);

    // n, max, mode, lr, latency, conv, epochs, err, eval, mid offset, mid err, poke
    run(4, 10, 0, 18'h00123, 9 + EVX,  1'b1, 1, 0, 0, 0, 0, 1'b1);
    run(4,  3, 1, 18'h3FFFF, 25 + EVX, 1'b0, 3, 4, (EVX != 0) ? 4 : 0, 9, 4, 1'b0);
    run(4,  0, 0, 18'h00055, 1,        1'b0, 0, 4, 0, 0, 0, 1'b0);
    run(4, 10, 2, 18'h20000, 17 + EVX, 1'b1, 2, 0, 0, 9, 2, 1'b0);
    run(0,  5, 0, 18'h0ABCD, 1,        1'b1, 0, 0, 0, 0, 0, 1'b0);

    // Reset during RUN of epoch 2; no record, so any done is flagged.
    @(negedge clk);
    mode = 2; num_samples = 5'd4; max_epochs = 16'd10; learning_rate = 18'h00777; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    run(4, 10, 0, 18'h00321, 9 + EVX, 1'b1, 1, 0, 0, 0, 0, 1'b0);

`ifdef PERCEPTRON_TRAINER_EVAL_EN
    run(4, 10, 3, 18'h01010, 16, 1'b1, 1, 0, 1, 0, 0, 1'b0);
`endif

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
